// File: rtl/instr_fetch_pkg.sv
// Shared fetch-path definitions: machine width, instruction size, reset PC and
// the {pc, instr} record carried through the fetch buffer.
package instr_fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with push, pop and flush.
// The head entry is presented combinationally so the consumer sees it with no added latency.
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [XLEN-1:0]            push_pc,
   input  logic [XLEN-1:0]            push_instr,
   input  logic                       pop,
   input  logic                       flush,
   output logic [XLEN-1:0]            head_pc,
   output logic [XLEN-1:0]            head_instr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign do_pop     = pop && !empty;
   assign do_push    = push && (!full || do_pop);
   assign head_pc    = mem[rd_ptr].pc;
   assign head_instr = mem[rd_ptr].instr;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; pointers and count alone define
   // which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues sequential word fetches, buffers in-order
// responses with their PCs, and squashes stale responses after a redirect.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   inflight_next;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     occupancy;
   logic            fifo_full;
   logic            fifo_empty;
   logic            req_fire;
   logic            rsp_take;
   logic            keep;
   logic            pop;
   logic            unused;

   assign imem_req_addr = fetch_pc;
   assign out_valid     = !reset && !fifo_empty;
   assign pop           = out_valid && out_ready;

   // A slot freed by this cycle's pop may be reused, so back-to-back issue is sustained.
   assign occupancy      = {1'b0, inflight} + {1'b0, fifo_count} - (CW+1)'(pop);
   assign imem_req_valid = !reset && (occupancy < (CW+1)'(DEPTH));
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding belong to pre-reset traffic and are ignored.
   assign rsp_take = imem_rsp_valid && (inflight != '0);
   assign keep     = rsp_take && (drop_cnt == '0) && !redirect_valid;

   assign unused = &{1'b0, fifo_full, redirect_pc[1:0]};

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      inflight_next = inflight;
      case ({req_fire, rsp_take})
         2'b10:   inflight_next = inflight + CW'(1);
         2'b01:   inflight_next = inflight - CW'(1);
         default: inflight_next = inflight;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight_next;
         if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            rsp_pc   <= align_pc(redirect_pc);
            drop_cnt <= inflight_next;
         end else begin
            if (req_fire) fetch_pc <= next_pc(fetch_pc);
            if (keep)     rsp_pc   <= next_pc(rsp_pc);
            if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (keep),
      .push_pc    (rsp_pc),
      .push_instr (imem_rsp_data),
      .pop        (pop),
      .flush      (redirect_valid),
      .head_pc    (out_pc),
      .head_instr (out_instr),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a latency-programmable memory model, an
// epoch-tagged scoreboard of expected {pc, instr}, a vector table and corner sequences.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; int epoch; } mem_ent_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { logic ov; logic [31:0] opc; logic rv; logic [31:0] raddr; } vec_t;

   mem_ent_t    mem_q[$];
   exp_t        sb[$];
   logic [31:0] out_log[$];
   logic [31:0] req_log[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int epoch    = 0;
   int lat      = 1;

   logic        ctl_reset       = 1'b1;
   logic        ctl_ready       = 1'b1;
   logic        ctl_out_ready   = 1'b1;
   logic        ctl_redirect    = 1'b0;
   logic [31:0] ctl_redirect_pc = 32'h0;

   function automatic logic [31:0] mem_data(input logic [31:0] addr);
      return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then observe handshakes.
   task automatic step();
      @(negedge clk);
      reset          = ctl_reset;
      imem_req_ready = ctl_ready;
      out_ready      = ctl_out_ready;
      redirect_valid = ctl_redirect;
      redirect_pc    = ctl_redirect_pc;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
      if (!ctl_reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_data(mem_q[0].addr);
         if (mem_q[0].epoch == epoch && !ctl_redirect)
            sb.push_back('{mem_q[0].addr, imem_rsp_data});
         void'(mem_q.pop_front());
      end
      #1;
      if (ctl_reset) begin
         mem_q.delete();
         sb.delete();
         epoch++;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got pc %h with nothing expected", out_pc);
            end else begin
               check("sb_pc", out_pc, sb[0].pc);
               check("sb_instr", out_instr, sb[0].instr);
               void'(sb.pop_front());
            end
            out_log.push_back(out_pc);
         end
         if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{imem_req_addr, cyc + lat, epoch});
            req_log.push_back(imem_req_addr);
         end
         if (ctl_redirect) begin
            sb.delete();
            epoch++;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      ctl_reset     = 1'b1;
      ctl_redirect  = 1'b0;
      ctl_ready     = 1'b1;
      ctl_out_ready = 1'b1;
      repeat (2) step();
      check("reset_req_valid", 32'(imem_req_valid), 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'h0);
      ctl_reset = 1'b0;
      out_log.delete();
      req_log.delete();
   endtask

   task automatic run_outs(input string name, input int n, input int budget);
      int k = 0;
      while (out_log.size() < n && k < budget) begin
         step();
         k++;
      end
      check(name, 32'(out_log.size() >= n), 32'h1);
   endtask

   task automatic run_reqs(input string name, input int n, input int budget);
      int k = 0;
      while (req_log.size() < n && k < budget) begin
         step();
         k++;
      end
      check(name, 32'(req_log.size() >= n), 32'h1);
   endtask

   vec_t vecs[6];

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;

      // Per-cycle expectations after reset with a zero-wait, 1-cycle memory.
      vecs[0] = '{1'b0, 32'h0,  1'b1, 32'h0};
      vecs[1] = '{1'b0, 32'h0,  1'b1, 32'h4};
      vecs[2] = '{1'b1, 32'h0,  1'b1, 32'h8};
      vecs[3] = '{1'b1, 32'h4,  1'b1, 32'hC};
      vecs[4] = '{1'b1, 32'h8,  1'b1, 32'h10};
      vecs[5] = '{1'b1, 32'hC,  1'b1, 32'h14};

      // Streaming at full rate
      lat = 1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         if (vecs[i].ov) check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].opc);
         check($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
         check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].raddr);
      end

      // Consumer stalled: buffer fills with two entries, then drains losslessly
      do_reset();
      ctl_out_ready = 1'b0;
      repeat (10) step();
      check("stall_req_count", 32'(req_log.size()), 32'd2);
      check("stall_req_valid", 32'(imem_req_valid), 32'h0);
      check("stall_out_valid", 32'(out_valid), 32'h1);
      check("stall_head_pc", out_pc, 32'h0);
      ctl_out_ready = 1'b1;
      run_outs("stall_drain_timeout", 4, 20);
      for (int i = 0; i < 4 && i < out_log.size(); i++)
         check($sformatf("stall_drain_pc%0d", i), out_log[i], 32'(4 * i));

      // Redirect with two requests in flight
      lat = 3;
      do_reset();
      repeat (2) step();
      check("redir_inflight", 32'(req_log.size()), 32'd2);
      ctl_redirect    = 1'b1;
      ctl_redirect_pc = 32'h0000_0103;
      step();
      ctl_redirect = 1'b0;
      out_log.delete();
      run_outs("redir_timeout", 2, 30);
      if (out_log.size() >= 2) begin
         check("redir_first_pc", out_log[0], 32'h0000_0100);
         check("redir_second_pc", out_log[1], 32'h0000_0104);
      end

      // Redirect coincident with a response and an output handshake
      lat = 1;
      do_reset();
      repeat (4) step();
      ctl_redirect    = 1'b1;
      ctl_redirect_pc = 32'h0000_0200;
      step();
      check("coinc_events", {29'b0, imem_rsp_valid, out_valid, out_ready}, 32'h7);
      ctl_redirect = 1'b0;
      out_log.delete();
      step();
      check("coinc_flushed", 32'(out_valid), 32'h0);
      run_outs("coinc_timeout", 1, 20);
      if (out_log.size() >= 1) check("coinc_first_pc", out_log[0], 32'h0000_0200);

      // Memory backpressure holds the address; fetch PC wraps at the top
      do_reset();
      repeat (2) step();
      ctl_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold%0d_req_valid", i), 32'(imem_req_valid), 32'h1);
         check($sformatf("hold%0d_req_addr", i), imem_req_addr, 32'h8);
      end
      ctl_ready = 1'b1;
      step();
      ctl_redirect    = 1'b1;
      ctl_redirect_pc = 32'hFFFF_FFFE;
      step();
      ctl_redirect = 1'b0;
      req_log.delete();
      out_log.delete();
      run_reqs("wrap_req_timeout", 2, 20);
      if (req_log.size() >= 2) begin
         check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
         check("wrap_req1", req_log[1], 32'h0000_0000);
      end
      run_outs("wrap_out_timeout", 2, 20);
      if (out_log.size() >= 2) begin
         check("wrap_out0", out_log[0], 32'hFFFF_FFFC);
         check("wrap_out1", out_log[1], 32'h0000_0000);
      end

      // Reset mid-stream with two in flight
      lat = 3;
      do_reset();
      repeat (2) step();
      check("midrst_inflight", 32'(req_log.size()), 32'd2);
      ctl_reset = 1'b1;
      step();
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      check("midrst_req_valid", 32'(imem_req_valid), 32'h0);
      ctl_reset = 1'b0;
      step();
      check("midrst_after_out_valid", 32'(out_valid), 32'h0);
      out_log.delete();
      run_outs("midrst_timeout", 1, 20);
      if (out_log.size() >= 1) check("midrst_first_pc", out_log[0], 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the maximum count of in-flight requests plus buffered instructions.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports SHALL be named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  response valid; in order; no backpressure.
REQ-010 imem_rsp_data  input  32  fetched instruction word.
REQ-011 redirect_valid  input  1  control-flow change (jal target) from downstream PC control.
REQ-012 redirect_pc  input  32  new fetch PC; bits [1:0] ignored.
REQ-013 out_valid  output  1  instruction available to execute stage.
REQ-014 out_ready  input  1  execute stage consumes the instruction.
REQ-015 out_instr  output  32  instruction word.
REQ-016 out_pc  output  32  address of out_instr.

Function
REQ-017 Request handshake SHALL be imem_req_valid && imem_req_ready; on it fetch_pc SHALL advance by 4 (mod 2^32, wrap-around permitted).
REQ-018 imem_req_valid SHALL be high only when inflight + fifo_count < DEPTH, so that a buffer slot is always reserved for every response.
REQ-019 Each imem_rsp_valid SHALL retire one in-flight request. If drop_cnt > 0, it SHALL decrement drop_cnt and discard the data. Otherwise it SHALL push {pc, data} into the FIFO, with the pc tracked per request in order.
REQ-020 The output handshake SHALL be out_valid && out_ready. out_valid SHALL equal FIFO not-empty. out_instr and out_pc SHALL present the FIFO head with zero added latency.
REQ-021 Latency: a response arriving in cycle N SHALL appear on out_valid in cycle N+1.
REQ-022 A push and a pop in the same cycle SHALL both occur, leaving the count unchanged.
REQ-023 On redirect_valid:
- the FIFO SHALL be flushed, regardless of any same-cycle pop;
- drop_cnt SHALL become the count of in-flight requests still unretired after this cycle, including a request accepted in the same cycle;
- a response in the same cycle SHALL be discarded;
- fetch_pc SHALL become {redirect_pc[31:2], 2'b00}.
REQ-024 Requests after a redirect SHALL issue from the cycle following the redirect, without waiting for drop_cnt to reach zero.
REQ-025 imem_req_addr SHALL remain stable while imem_req_valid is high and imem_req_ready is low.
REQ-026 inflight and drop_cnt SHALL never exceed DEPTH, and the FIFO SHALL never overflow.

Reset
REQ-027 While reset is high, imem_req_valid SHALL be 0, out_valid SHALL be 0, fetch_pc SHALL be RESET_PC, and inflight, drop_cnt and fifo_count SHALL be 0.
REQ-028 The first request SHALL be issued in the first cycle after reset deasserts.
REQ-029 Any response arriving during reset or for a pre-reset request SHALL be ignored. The memory SHALL be reset together with this block.

Structure
REQ-030 A shared package SHALL hold XLEN=32, INSTR_BYTES=4 and the default RESET_PC.
REQ-031 Buffering SHALL be one sub-module, fetch_fifo: parameterised depth, {pc,instr} entries, push/pop/flush, full/empty flags.

Verification
REQ-032 Zero-wait memory with 1-cycle response and out_ready=1: out_pc SHALL be 0,4,8,12 on consecutive cycles after the first response.
REQ-033 out_ready=0 for 10 cycles: exactly 2 instructions (pc 0,4) SHALL be buffered, imem_req_valid SHALL be 0, and no instruction SHALL be lost after release.
REQ-034 Redirect to 32'h0000_0103 with 2 requests in flight: both responses SHALL be dropped, and the next out_pc SHALL be 32'h100.
REQ-035 Redirect coincident with a response and an output handshake: the FIFO SHALL be emptied and the only next output SHALL be from the redirect target.
REQ-036 With imem_req_ready=0 for 5 cycles, imem_req_addr SHALL hold at 8. Starting from fetch_pc 32'hFFFF_FFFC, the next fetch_pc SHALL wrap to 0.
REQ-037 Reset asserted mid-stream with 2 in flight: out_valid SHALL be 0 in the next cycle, and after release the first out_pc SHALL be RESET_PC.
